// File: rtl/rv32m_pkg.sv
// Shared encodings for the rv32m issue/writeback controller: M-extension
// opcode fields, funct3 operation selects, result error codes and FSM states.
package rv32m_pkg;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_UNIT    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/rv32m_issue_decode.sv
// Combinational M-extension decode and legality check; with RV32M_FASTPATH_EN
// it also flags ops whose result is known without running the unit.
module rv32m_issue_decode (
    input  logic [31:0] instr,
`ifdef RV32M_FASTPATH_EN
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
`endif
    output logic        legal,
    output logic [2:0]  funct3,
    output logic [4:0]  rd,
    output logic        fast_hit,
    output logic [31:0] fast_result
);
    import rv32m_pkg::*;

    // Register-index fields are irrelevant here: operands arrive already read.
    logic [9:0] unused_src_idx;
    assign unused_src_idx = instr[24:15];

    assign legal  = (instr[6:0] == OPC_OP) && (instr[31:25] == F7_MULDIV);
    assign funct3 = instr[14:12];
    assign rd     = instr[11:7];

    always_comb begin
        fast_hit    = 1'b0;
        fast_result = '0;
`ifdef RV32M_FASTPATH_EN
        if (legal) begin
            case (funct3)
                F3_DIV, F3_DIVU: begin
                    if (rs2_val == '0) begin
                        fast_hit    = 1'b1;
                        fast_result = '1;
                    end
                end
                F3_REM, F3_REMU: begin
                    if (rs2_val == '0) begin
                        fast_hit    = 1'b1;
                        fast_result = rs1_val;
                    end
                end
                default: begin
                    if ((rs1_val == '0) || (rs2_val == '0)) begin
                        fast_hit    = 1'b1;
                        fast_result = '0;
                    end
                end
            endcase
        end
`endif
    end

endmodule

// File: rtl/rv32m_issue.sv
// Issue/writeback controller for rv32m: one op in flight, clear/issue/wait
// sequencing with timeout, held result until writeback accepts. RV32M_FASTPATH_EN enables trivial-result bypass.
module rv32m_issue #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int XLEN           = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_instr,
    input  logic [XLEN-1:0] req_rs1_val,
    input  logic [XLEN-1:0] req_rs2_val,
    output logic            m_rst,
    output logic            m_in_valid,
    output logic [XLEN-1:0] m_rs1,
    output logic [XLEN-1:0] m_rs2,
    output logic [2:0]      m_funct3,
    input  logic [XLEN-1:0] m_rd,
    input  logic            m_out_valid,
    input  logic            m_in_error,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] res_data,
    output logic [4:0]      res_rd,
    output logic            res_wb_en,
    output logic [1:0]      res_err_code,
    output logic            busy
);
    import rv32m_pkg::*;

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic            dec_legal;
    logic [2:0]      dec_funct3;
    logic [4:0]      dec_rd;
    logic            dec_fast_hit;
    logic [31:0]     dec_fast_result;

    rv32m_issue_decode u_decode (
        .instr       (req_instr),
`ifdef RV32M_FASTPATH_EN
        .rs1_val     (req_rs1_val),
        .rs2_val     (req_rs2_val),
`endif
        .legal       (dec_legal),
        .funct3      (dec_funct3),
        .rd          (dec_rd),
        .fast_hit    (dec_fast_hit),
        .fast_result (dec_fast_result)
    );

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            req_ready_q, req_ready_d;
    logic            busy_q, busy_d;
    logic            m_rst_q, m_rst_d;
    logic            m_in_valid_q, m_in_valid_d;
    logic [XLEN-1:0] m_rs1_q, m_rs1_d;
    logic [XLEN-1:0] m_rs2_q, m_rs2_d;
    logic [2:0]      m_funct3_q, m_funct3_d;
    logic            res_valid_q, res_valid_d;
    logic [XLEN-1:0] res_data_q, res_data_d;
    logic [4:0]      res_rd_q, res_rd_d;
    logic            res_wb_en_q, res_wb_en_d;
    logic [1:0]      res_err_q, res_err_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        m_rst_d      = m_rst_q;
        m_in_valid_d = 1'b0;
        m_rs1_d      = m_rs1_q;
        m_rs2_d      = m_rs2_q;
        m_funct3_d   = m_funct3_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_rd_d     = res_rd_q;
        res_wb_en_d  = res_wb_en_q;
        res_err_d    = res_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    res_rd_d = dec_rd;
                    if (!dec_legal) begin
                        state_d     = RESP;
                        res_valid_d = 1'b1;
                        res_data_d  = '0;
                        res_err_d   = ERR_ILLEGAL;
                        res_wb_en_d = 1'b0;
                    end else if (dec_fast_hit) begin
                        state_d     = RESP;
                        res_valid_d = 1'b1;
                        res_data_d  = dec_fast_result;
                        res_err_d   = ERR_NONE;
                        res_wb_en_d = (dec_rd != 5'd0);
                    end else begin
                        // m_rs*/m_funct3 double as the operand latch and stay put until the next legal op.
                        state_d    = CLR;
                        m_rst_d    = 1'b1;
                        m_rs1_d    = req_rs1_val;
                        m_rs2_d    = req_rs2_val;
                        m_funct3_d = dec_funct3;
                    end
                end
            end
            CLR: begin
                state_d      = ISSUE;
                m_rst_d      = 1'b0;
                m_in_valid_d = 1'b1;
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (m_out_valid) begin
                    state_d     = RESP;
                    res_valid_d = 1'b1;
                    res_data_d  = m_rd;
                    res_err_d   = m_in_error ? ERR_UNIT : ERR_NONE;
                    res_wb_en_d = (res_rd_q != 5'd0) && !m_in_error;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = RESP;
                    res_valid_d = 1'b1;
                    res_data_d  = '0;
                    res_err_d   = ERR_TIMEOUT;
                    res_wb_en_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            m_rst_q      <= 1'b1;
            m_in_valid_q <= 1'b0;
            m_rs1_q      <= '0;
            m_rs2_q      <= '0;
            m_funct3_q   <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_rd_q     <= '0;
            res_wb_en_q  <= 1'b0;
            res_err_q    <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
            m_rst_q      <= m_rst_d;
            m_in_valid_q <= m_in_valid_d;
            m_rs1_q      <= m_rs1_d;
            m_rs2_q      <= m_rs2_d;
            m_funct3_q   <= m_funct3_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_rd_q     <= res_rd_d;
            res_wb_en_q  <= res_wb_en_d;
            res_err_q    <= res_err_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign busy         = busy_q;
    assign m_rst        = m_rst_q;
    assign m_in_valid   = m_in_valid_q;
    assign m_rs1        = m_rs1_q;
    assign m_rs2        = m_rs2_q;
    assign m_funct3     = m_funct3_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_rd       = res_rd_q;
    assign res_wb_en    = res_wb_en_q;
    assign res_err_code = res_err_q;

endmodule

// File: doc/rv32m_issue.md
Name: rv32m_issue

Overview:
- Issue/writeback controller that sits directly upstream of the rv32m multiply/divide unit.
- Accepts an RV32 instruction word plus already-read operand values over a valid/ready request channel, and decodes and legality-checks the M-extension encoding.
- Sequences rv32m through its clear / in_valid / out_valid protocol, then presents the result, destination index and error status on a valid/ready result channel to writeback.
- One instruction in flight at a time.

Parameters:
- TIMEOUT_CYCLES, 64: WAIT-state cycles allowed before the operation is abandoned; minimum 2.
- XLEN, 32: operand and result width; only 32 is supported.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_instr  in  32  instruction word.
- req_rs1_val  in  32  rs1 operand value.
- req_rs2_val  in  32  rs2 operand value.
- m_rst  out  1  active-high clear to rv32m.
- m_in_valid  out  1  operands-ready pulse to rv32m.
- m_rs1  out  32  operand to rv32m.
- m_rs2  out  32  operand to rv32m.
- m_funct3  out  3  operation select to rv32m.
- m_rd  in  32  rv32m result.
- m_out_valid  in  1  rv32m result valid.
- m_in_error  in  1  rv32m error flag.
- res_valid  out  1  result present.
- res_ready  in  1  writeback accepts the result.
- res_data  out  32  result value.
- res_rd  out  5  destination register index.
- res_wb_en  out  1  write enable; 0 when rd==0 or res_err_code!=0.
- res_err_code  out  2  00 ok, 01 illegal, 10 unit error, 11 timeout.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst==0 at an edge):
  - state <= IDLE.
  - req_ready=1, res_valid=0, res_data=0, res_rd=0, res_wb_en=0, res_err_code=0, busy=0.
  - m_in_valid=0, m_rs1=0, m_rs2=0, m_funct3=0, m_rst=1 while rst is low.
  - Reset overrides every state, including mid-WAIT; the in-flight op is dropped with no result.
- All outputs are registered. req_ready=1 only in IDLE.
- Decode: legal iff req_instr[6:0]==7'b0110011 and req_instr[31:25]==7'b0000001. funct3=req_instr[14:12], rd=req_instr[11:7].
- State machine, where T is the accept edge (req_valid & req_ready):
  - IDLE: on accept, latch the operands, funct3 and rd.
    - Illegal instruction -> RESP with res_err_code=01, res_data=0; rv32m is not touched.
    - Legal instruction -> CLR.
  - CLR (cycle T+1): m_rst=1; m_rs1/m_rs2/m_funct3 driven from the latch and held unchanged through WAIT.
  - ISSUE (T+2): m_rst=0, m_in_valid=1 for exactly one cycle; the timeout counter clears.
  - WAIT (T+3 onward): m_out_valid is sampled.
    - First cycle it is 1: capture m_rd, go to RESP. Code is 10 if m_in_error is 1, else 00.
    - m_out_valid seen during CLR or ISSUE is stale and ignored.
    - If the counter reaches TIMEOUT_CYCLES-1 without m_out_valid: code 11, res_data=0, go to RESP.
  - RESP: res_valid=1 and all res_* held stable until res_ready=1. On that edge res_valid clears and state returns to IDLE. req_ready returns to 1 the following cycle; there is no same-cycle re-accept.
- res_wb_en = (rd!=0) && (code==00).
- res_data passes through unchanged even when rd==0.
- Minimum latency for a legal op: res_valid rises 1 cycle after the edge at which m_out_valid is sampled in WAIT.

Optional Feature:
- Macro: RV32M_FASTPATH_EN.
- Defined:
  - A legal op with a trivial result skips CLR/ISSUE/WAIT and enters RESP at T+1 with code 00.
    - DIV/DIVU with rs2==0 -> 0xFFFFFFFF.
    - REM/REMU with rs2==0 -> rs1.
    - Any MUL* with rs1==0 or rs2==0 -> 0.
  - rv32m sees no m_in_valid for these ops.
- Undefined: every legal op goes through rv32m.

Decomposition:
- Package rv32m_pkg holds:
  - funct3 constants MUL..REMU (000..111);
  - OPC_OP=7'b0110011 and F7_MULDIV=7'b0000001;
  - error codes ERR_NONE/ERR_ILLEGAL/ERR_UNIT/ERR_TIMEOUT;
  - the state enum IDLE/CLR/ISSUE/WAIT/RESP.
- One combinational sub-module, rv32m_issue_decode: takes the instruction (plus operands when fastpath is on) and outputs legal, funct3, rd, fast_hit and fast_result.
- rv32m itself is instantiated beside this block, not inside it.

Test Plan:
1. Mul: instr 0x022081B3 (mul x3,x1,x2), rs1=4, rs2=0xFFFFFFFF, against a real rv32m.
   - Required: m_rst at T+1, m_in_valid at T+2, then res_data=0xFFFFFFFC, res_rd=3, res_wb_en=1, code 00.
2. Div: instr 0x0220C2B3 (div x5,x1,x2), rs1=0xFFFFFFF9 (-7), rs2=2.
   - Required: res_data=0xFFFFFFFD, res_rd=5, code 00.
   - With RV32M_FASTPATH_EN and rs2=0: res_data=0xFFFFFFFF at T+1 and no m_in_valid pulse.
3. Illegal: instr 0x002081B3 (add).
   - Required: res_valid at T+1, code 01, res_wb_en=0, m_in_valid never asserted.
4. Backpressure and x0: instr 0x02208033 (mul x0,x1,x2) with res_ready held 0 for 5 cycles.
   - Required: res_* stable, req_ready=0 throughout, res_wb_en=0; accepted on the first res_ready=1 cycle.
5. Timeout and reset:
   - rv32m stub that never asserts out_valid -> after 64 WAIT cycles, code 11 and res_data=0.
   - A second run with rst=0 asserted at WAIT cycle 10 -> IDLE next edge, res_valid=0, req_ready=1 after rst rises.
